// File: rtl/ahb_apb_arbiter.sv
// rtl/ahb_apb_arbiter.sv - round-robin arbiter sharing the AHB-to-APB bridge slave port
module ahb_apb_arbiter #(
   parameter int NO_OF_MASTERS = 4,
   parameter int MAX_HOLD      = 8
) (
   input  logic                                 HCLK,
   input  logic                                 HRESETn,
   input  logic [NO_OF_MASTERS-1:0]             HBUSREQ,
   input  logic [NO_OF_MASTERS-1:0]             HLOCK,
   input  logic [NO_OF_MASTERS-1:0][31:0]       M_HADDR,
   input  logic [NO_OF_MASTERS-1:0][1:0]        M_HTRANS,
   input  logic [NO_OF_MASTERS-1:0]             M_HWRITE,
   input  logic [NO_OF_MASTERS-1:0][31:0]       M_HWDATA,
   output logic [NO_OF_MASTERS-1:0]             HGRANT,
   output logic [$clog2(NO_OF_MASTERS)-1:0]     HMASTER,
   output logic [31:0]                          HADDR,
   output logic [1:0]                           HTRANS,
   output logic                                 HWRITE,
   output logic                                 HSEL,
   output logic [31:0]                          HWDATA,
   input  logic                                 HREADY,
   input  logic [1:0]                           HRESP
);

   localparam int MW = $clog2(NO_OF_MASTERS);
   localparam logic [1:0] TRANS_IDLE = 2'b00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [NO_OF_MASTERS-1:0] grant_q;
   logic [MW-1:0]            hmaster_q;
   logic [MW-1:0]            last_grant_q;
   logic [7:0]               beat_cnt_q;
   logic [MW-1:0]            dphase_owner_q;
   logic                     dphase_vld_q;

   logic [MW-1:0]            winner;
   logic [MW-1:0]            cand;
   logic                     found;
   logic [NO_OF_MASTERS-1:0] winner_onehot;
   logic                     any_req;
   logic                     accept;
   logic [7:0]               beat_next;
   logic                     other_req;
   logic                     rel_idle;
   logic                     rel_hold;
   logic                     do_release;
   logic                     unused_hresp;

   // Responses go straight from the bridge to the masters; errors never steer arbitration.
   assign unused_hresp = ^HRESP;

   assign HGRANT  = grant_q;
   assign HMASTER = hmaster_q;
   assign HWDATA  = M_HWDATA[dphase_owner_q];

   // Round-robin pick: first requester scanning upward from the previous owner, wrapping.
   always_comb begin
      winner = last_grant_q;
      cand   = '0;
      found  = 1'b0;
      for (int i = 1; i <= NO_OF_MASTERS; i++) begin
         cand = MW'((int'(last_grant_q) + i) % NO_OF_MASTERS);
         if (!found && HBUSREQ[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign winner_onehot = {{(NO_OF_MASTERS-1){1'b0}}, 1'b1} << winner;
   assign any_req       = |HBUSREQ;

   // Address phase reaches the bridge only while a master owns the bus.
   always_comb begin
      HADDR  = '0;
      HTRANS = TRANS_IDLE;
      HWRITE = 1'b0;
      HSEL   = 1'b0;
      if (state_q == OWN) begin
         HADDR  = M_HADDR[hmaster_q];
         HTRANS = M_HTRANS[hmaster_q];
         HWRITE = M_HWRITE[hmaster_q];
         HSEL   = M_HTRANS[hmaster_q][1];
      end
   end

   assign accept    = (state_q == OWN) && HTRANS[1] && HREADY;
   // The hold count includes the transfer accepted this cycle, so an owner gets
   // exactly MAX_HOLD transfers per tenure when others are waiting.
   assign beat_next = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + {7'd0, accept};
   assign other_req = |(HBUSREQ & ~grant_q);
   assign rel_idle  = !HBUSREQ[hmaster_q] && (M_HTRANS[hmaster_q] == TRANS_IDLE);
   assign rel_hold  = (beat_next >= 8'(MAX_HOLD)) && !HLOCK[hmaster_q] && other_req &&
                      (accept || (HTRANS == TRANS_IDLE));
   assign do_release = (state_q == OWN) && (rel_idle || rel_hold);

   // State register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state: grant, hold until release, then wait out the last data phase.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = OWN;
         OWN:     if (do_release) state_d = DRAIN;
         DRAIN:   if (!dphase_vld_q || HREADY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant, owner, hold counter and data-phase tracking.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         grant_q        <= '0;
         hmaster_q      <= '0;
         last_grant_q   <= MW'(NO_OF_MASTERS - 1);
         beat_cnt_q     <= '0;
         dphase_owner_q <= '0;
         dphase_vld_q   <= 1'b0;
      end else begin
         if (accept) begin
            dphase_owner_q <= hmaster_q;
            dphase_vld_q   <= 1'b1;
         end else if (HREADY) begin
            dphase_vld_q   <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q      <= winner_onehot;
                  hmaster_q    <= winner;
                  last_grant_q <= winner;
                  beat_cnt_q   <= '0;
               end
            end
            OWN: begin
               beat_cnt_q <= beat_next;
               if (do_release) grant_q <= '0;
            end
            default: grant_q <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_arbiter.sv
// tb/tb_ahb_apb_arbiter.sv - directed self-checking bench for ahb_apb_arbiter
module tb_ahb_apb_arbiter;

   localparam int N = 4;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] T_IDLE = 2'b00;

   logic              HCLK = 1'b0;
   logic              HRESETn;
   logic [N-1:0]      HBUSREQ;
   logic [N-1:0]      HLOCK;
   logic [N-1:0][31:0] M_HADDR;
   logic [N-1:0][1:0] M_HTRANS;
   logic [N-1:0]      M_HWRITE;
   logic [N-1:0][31:0] M_HWDATA;
   logic [N-1:0]      HGRANT;
   logic [1:0]        HMASTER;
   logic [31:0]       HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic              HSEL;
   logic [31:0]       HWDATA;
   logic              HREADY;
   logic [1:0]        HRESP;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 HCLK = ~HCLK;

   ahb_apb_arbiter #(.NO_OF_MASTERS(N), .MAX_HOLD(4)) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HBUSREQ  (HBUSREQ),
      .HLOCK    (HLOCK),
      .M_HADDR  (M_HADDR),
      .M_HTRANS (M_HTRANS),
      .M_HWRITE (M_HWRITE),
      .M_HWDATA (M_HWDATA),
      .HGRANT   (HGRANT),
      .HMASTER  (HMASTER),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HWRITE   (HWRITE),
      .HSEL     (HSEL),
      .HWDATA   (HWDATA),
      .HREADY   (HREADY),
      .HRESP    (HRESP)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input int i, input logic req, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      HBUSREQ[i]  = req;
      M_HTRANS[i] = tr;
      M_HWRITE[i] = wr;
      M_HADDR[i]  = a;
      M_HWDATA[i] = d;
   endtask

   task automatic set_defaults();
      HBUSREQ  = '0;
      HLOCK    = '0;
      M_HTRANS = '0;
      M_HWRITE = '0;
      HREADY   = 1'b1;
      HRESP    = 2'b00;
      for (int i = 0; i < N; i++) begin
         M_HADDR[i]  = 32'h1000_0000 | 32'(i);
         M_HWDATA[i] = 32'hD000_0000 | 32'(i);
      end
   endtask

   task automatic do_reset();
      set_defaults();
      HRESETn = 1'b0;
      cyc();
      cyc();
      HRESETn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc;
      int held;
      logic [N-1:0] fair_order [5];
      fair_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset with every master requesting.
      set_defaults();
      HBUSREQ  = '1;
      M_HTRANS = {N{NONSEQ}};
      HRESETn  = 1'b0;
      cyc(); cyc(); cyc(); #1;
      chk("rst_grant",  HGRANT,  0);
      chk("rst_hsel",   HSEL,    0);
      chk("rst_htrans", HTRANS,  0);
      chk("rst_master", HMASTER, 0);
      chk("rst_haddr",  HADDR,   0);
      chk("rst_hwdata", HWDATA,  32'hD000_0000);
      HRESETn = 1'b1;
      cyc(); #1;
      chk("rst_first_grant", HGRANT, 4'b0001);
      chk("rst_first_haddr", HADDR,  32'h1000_0000);
      chk("rst_first_hsel",  HSEL,   1);

      // Single requester: master 2.
      do_reset();
      drive(2, 1'b1, NONSEQ, 1'b1, 32'h0000_0104, 32'hA5A5_0001);
      cyc(); #1;
      chk("sr_grant",  HGRANT,  4'b0100);
      chk("sr_master", HMASTER, 2);
      chk("sr_haddr",  HADDR,   32'h0000_0104);
      chk("sr_hsel",   HSEL,    1);
      chk("sr_hwrite", HWRITE,  1);
      cyc();
      drive(2, 1'b0, T_IDLE, 1'b0, 32'h0, 32'hA5A5_0001);
      #1;
      chk("sr_hwdata", HWDATA, 32'hA5A5_0001);
      chk("sr_htrans", HTRANS, 0);
      cyc(); #1;
      chk("sr_released", HGRANT, 0);

      // Simultaneous requests from masters 0 and 1.
      do_reset();
      drive(0, 1'b1, NONSEQ, 1'b0, 32'h0000_0010, 32'hD000_0000);
      drive(1, 1'b1, NONSEQ, 1'b1, 32'h0000_0110, 32'h1111_0001);
      cyc(); #1;
      chk("sim_first", HGRANT, 4'b0001);
      cyc(); #1;
      cyc();
      drive(0, 1'b0, T_IDLE, 1'b0, 32'h0, 32'hD000_0000);
      #1;
      chk("sim_hold", HGRANT, 4'b0001);
      cyc(); #1;
      chk("sim_drain_grant", HGRANT, 0);
      chk("sim_drain_trans", HTRANS, 0);
      chk("sim_drain_haddr", HADDR,  0);
      cyc(); #1;
      chk("sim_idle_grant", HGRANT, 0);
      cyc(); #1;
      chk("sim_second",  HGRANT,  4'b0010);
      chk("sim_master",  HMASTER, 1);
      chk("sim_haddr",   HADDR,   32'h0000_0110);

      // Fairness: all four back-to-back, MAX_HOLD = 4.
      do_reset();
      for (int i = 0; i < N; i++)
         drive(i, 1'b1, NONSEQ, 1'b0, 32'h2000_0000 | 32'(i), 32'hD000_0000 | 32'(i));
      #1;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (HGRANT == '0 && n < 10) begin
            cyc(); #1;
            n++;
         end
         chk("fair_gap", n, (k == 0) ? 1 : 2);
         chk("fair_grant", HGRANT, fair_order[k]);
         acc  = 0;
         held = 0;
         while (HGRANT != '0 && held < 20) begin
            if (HTRANS[1] && HREADY) acc++;
            held++;
            cyc(); #1;
         end
         chk("fair_beats", acc, 4);
      end

      // Lock: master 1 keeps the bus past MAX_HOLD while master 3 waits.
      do_reset();
      drive(1, 1'b1, NONSEQ, 1'b1, 32'h0000_0300, 32'h1111_0001);
      HLOCK[1] = 1'b1;
      drive(3, 1'b1, NONSEQ, 1'b0, 32'h0000_0500, 32'hD000_0003);
      held = 0;
      for (int c = 0; c < 12; c++) begin
         cyc(); #1;
         if (HGRANT == 4'b0010 && HTRANS == NONSEQ) held++;
      end
      chk("lock_held", held, 12);
      cyc();
      HLOCK[1] = 1'b0;
      #1;
      chk("lock_unlock_cycle", HGRANT, 4'b0010);
      n = 0;
      while (HGRANT != 4'b1000 && n < 10) begin
         cyc(); #1;
         n++;
      end
      chk("lock_latency", n, 3);
      chk("lock_grant", HGRANT, 4'b1000);

      // Wait states on the last data phase, then reset mid-transfer.
      do_reset();
      drive(1, 1'b1, NONSEQ, 1'b1, 32'h0000_0400, 32'h1111_0001);
      drive(2, 1'b1, NONSEQ, 1'b0, 32'h0000_0600, 32'h2222_0002);
      cyc(); #1;
      chk("ws_grant", HGRANT, 4'b0010);
      cyc();
      drive(1, 1'b0, T_IDLE, 1'b0, 32'h0, 32'h1111_0001);
      HREADY = 1'b0;
      #1;
      chk("ws_hwdata_first", HWDATA, 32'h1111_0001);
      for (int c = 0; c < 4; c++) begin
         cyc(); #1;
         chk("ws_hwdata", HWDATA, 32'h1111_0001);
         chk("ws_nogrant", HGRANT, 0);
      end
      cyc();
      HREADY = 1'b1;
      #1;
      chk("ws_ready_cycle", HGRANT, 0);
      cyc(); #1;
      chk("ws_idle_cycle", HGRANT, 0);
      cyc(); #1;
      chk("ws_next_owner", HGRANT, 4'b0100);
      cyc(); #1;
      chk("mr_hwdata_pre", HWDATA, 32'h2222_0002);
      chk("mr_htrans_pre", HTRANS, NONSEQ);
      HRESETn = 1'b0;
      drive(0, 1'b1, NONSEQ, 1'b0, 32'h0000_0700, 32'hD000_0000);
      drive(3, 1'b1, NONSEQ, 1'b0, 32'h0000_0800, 32'hD000_0003);
      #1;
      chk("mr_grant",  HGRANT,  0);
      chk("mr_master", HMASTER, 0);
      chk("mr_htrans", HTRANS,  0);
      chk("mr_hsel",   HSEL,    0);
      chk("mr_haddr",  HADDR,   0);
      chk("mr_hwdata", HWDATA,  32'hD000_0000);
      cyc();
      HRESETn = 1'b1;
      cyc(); #1;
      chk("mr_restart", HGRANT, 4'b0001);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
